irq_ctrl: RTL
=============

Name:
irq_ctrl

Overview:
Interrupt controller directly downstream of the timer slave. It consumes timer_irq on source 0 and up to N_SRC-1 further peripheral lines. The block latches requests into pending bits, masks them with an enable register, and presents one prioritised, non-nested interrupt to the core. Software uses a claim/complete register pair to take and retire each interrupt. Registers are accessed over a simple single-cycle register port, which the system bridge drives.

Parameters:
N_SRC, 8, number of interrupt sources (1..31); bit 0 is reserved for timer_irq
ADDR_WIDTH, 5, byte address width of register port
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
irq_src  input  N_SRC  interrupt request lines, same clock domain; bit 0 = timer_irq
reg_req  input  1  register access strobe, one cycle per access
reg_we  input  1  1 = write, 0 = read
reg_addr  input  ADDR_WIDTH  byte address, word aligned
reg_wdata  input  DATA_WIDTH  write data
reg_rvalid  output  1  pulses one cycle after every reg_req (read or write)
reg_rdata  output  DATA_WIDTH  read data, valid with reg_rvalid, 0 for writes
irq_o  output  1  interrupt request to core
irq_id_o  output  5  id+1 of highest-priority enabled pending source; 0 = none

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: pending, enable, src_q, in_service_valid, in_service_id, reg_rvalid and reg_rdata are all 0, so irq_o = 0 and irq_id_o = 0.
- Input stage: irq_src is registered once into src_q.
- Pending set: pending[i] sets on the clock edge after src_q[i] = 1.
  - The set is blocked while in_service_valid is 1 and in_service_id equals i.
  - Pending bits are independent of enable; a disabled source still latches.
- Priority: fixed, lowest index wins. best = lowest i with pending[i] & enable[i].
- Outputs: irq_id_o = best+1, or 0 if none. irq_o = (irq_id_o != 0) & ~in_service_valid. Both are combinational from registered state.
- Latency: irq_o rises in the 2nd cycle after irq_src is first sampled high.
- Register port: always accepts accesses, no stall. reg_rvalid and reg_rdata are registered, giving 1-cycle latency.
- Register map (word offsets):
  - 0x00 PENDING: read-only. Writes ignored.
  - 0x04 ENABLE: read/write, N_SRC bits. Upper bits read 0.
  - 0x08 CLAIM: read returns irq_id_o.
    - If the value is nonzero and in_service_valid = 0, in the same cycle: pending[best] is cleared, in_service_valid = 1, in_service_id = best.
    - If no source is pending, or one is already in service, the read returns 0 and no state changes.
    - Writes to CLAIM are ignored.
  - 0x0C COMPLETE: write id+1.
    - Clears in_service_valid only if in_service_valid = 1 and wdata[4:0] = in_service_id+1.
    - Otherwise the write is ignored. Reads return 0.
  - 0x10 TRIGGER: see Optional Feature.
  - 0x14 STATUS: read-only. bit0 = irq_o, bit1 = in_service_valid, bits[12:8] = in_service_id+1 (0 if none).
  - Unmapped offsets: read 0, writes ignored.
- Simultaneous events:
  - Claim clear beats a pending set for the claimed source in the same cycle. In edge mode that edge is dropped.
  - A set on any other source proceeds normally.
  - An ENABLE write in the same cycle as a CLAIM read cannot happen, because there is one access per cycle.
- Level semantics: a source still asserted after COMPLETE re-pends on the next edge and re-raises irq_o.
- Reset mid-operation: all state, including in_service, is cleared. Any outstanding reg_rvalid is suppressed.

Optional Feature:
Macro IRQ_CTRL_EDGE_EN.
- Defined:
  - TRIGGER (0x10) is a read/write N_SRC-bit register, reset 0.
  - For TRIGGER[i] = 1, pending[i] sets only on a rising edge of src_q[i] (src_q[i] & ~src_q_d[i]). src_q_d is an extra register, reset 0.
  - For TRIGGER[i] = 0, behaviour is level as above.
  - Latency for edge sources is the same as for level sources.
- Not defined:
  - TRIGGER reads 0 and writes are ignored.
  - All sources are level-triggered.
  - No src_q_d registers exist.

Test Plan:
1. Reset → irq_o=0, irq_id_o=0. Reads of 0x00, 0x04, 0x14 return 0x0.
2. Level path: ENABLE=0x01, pulse-hold irq_src[0]=1 at cycle 10.
   - irq_o=1 at cycle 12. CLAIM read returns 1.
   - irq_o=0 next cycle. STATUS reads 0x102.
   - Drop the source, write COMPLETE=1 → STATUS=0x000.
3. Priority: ENABLE=0x0C, irq_src=0x0C held → irq_id_o=3.
   - CLAIM returns 3. Then a CLAIM while source 2 is in service returns 0.
   - COMPLETE=3, then CLAIM returns 4.
4. Masking and bad complete:
   - irq_src[5]=1 with ENABLE=0 → PENDING=0x20, irq_o=0.
   - ENABLE=0x20 → irq_o=1. CLAIM returns 6.
   - COMPLETE=2 → still in service. COMPLETE=6 → cleared.
5. Edge mode (IRQ_CTRL_EDGE_EN): TRIGGER=0x02, ENABLE=0x02.
   - A 1-cycle pulse on irq_src[1] gives PENDING=0x02.
   - A source held high after claim and complete does not re-pend.
6. Reset mid-service: claim source 0, assert rst 1 cycle → STATUS=0, PENDING=0, ENABLE=0, irq_o=0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised, non-nested interrupt controller with pending/enable masking and a claim/complete handshake.
// Optional per-source edge triggering is enabled by defining IRQ_CTRL_EDGE_EN.
module irq_ctrl #(
  parameter int N_SRC      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      irq_src,
  input  logic                  reg_req,
  input  logic                  reg_we,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_rvalid,
  output logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  irq_o,
  output logic [4:0]            irq_id_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING  = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE   = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLAIM    = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COMPLETE = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TRIGGER  = ADDR_WIDTH'('h10);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS   = ADDR_WIDTH'('h14);

  logic [N_SRC-1:0]      src_q;
  logic [N_SRC-1:0]      pending;
  logic [N_SRC-1:0]      enable;
  logic [N_SRC-1:0]      trigger;
  logic [N_SRC-1:0]      set_src;
  logic [N_SRC-1:0]      block_mask;
  logic [N_SRC-1:0]      claim_mask;
  logic                  in_service_valid;
  logic [4:0]            in_service_id;
  logic                  found;
  logic [4:0]            best;
  logic                  rd;
  logic                  wr;
  logic                  claim_fire;
  logic                  complete_fire;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  unused_wdata;

  assign unused_wdata = ^reg_wdata[DATA_WIDTH-1:N_SRC];

  // Fixed priority: the lowest-indexed enabled pending source wins.
  always_comb begin
    found = 1'b0;
    best  = 5'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i] && enable[i]) begin
        found = 1'b1;
        best  = 5'(i);
      end
    end
  end

  assign irq_id_o = found ? best + 5'd1 : 5'd0;
  assign irq_o    = found & ~in_service_valid;

  assign rd            = reg_req & ~reg_we;
  assign wr            = reg_req & reg_we;
  assign claim_fire    = rd && (reg_addr == ADDR_CLAIM) && irq_o;
  assign complete_fire = wr && (reg_addr == ADDR_COMPLETE) && in_service_valid &&
                         (reg_wdata[4:0] == in_service_id + 5'd1);

  always_comb begin
    block_mask = '0;
    claim_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      block_mask[i] = in_service_valid && (in_service_id == 5'(i));
      claim_mask[i] = claim_fire && (best == 5'(i));
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0] src_q_d;

  // Edge sources only pend on a 0->1 transition of the registered input.
  assign set_src = src_q & ~(trigger & src_q_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_d <= '0;
      trigger <= '0;
    end else begin
      src_q_d <= src_q;
      if (wr && (reg_addr == ADDR_TRIGGER)) trigger <= reg_wdata[N_SRC-1:0];
    end
  end
`else
  assign trigger = '0;
  assign set_src = src_q;
`endif

  always_comb begin
    rdata_nxt = '0;
    if (rd) begin
      case (reg_addr)
        ADDR_PENDING: rdata_nxt[N_SRC-1:0] = pending;
        ADDR_ENABLE:  rdata_nxt[N_SRC-1:0] = enable;
        ADDR_CLAIM:   rdata_nxt[4:0]       = irq_o ? irq_id_o : 5'd0;
        ADDR_TRIGGER: rdata_nxt[N_SRC-1:0] = trigger;
        ADDR_STATUS: begin
          rdata_nxt[0]    = irq_o;
          rdata_nxt[1]    = in_service_valid;
          rdata_nxt[12:8] = in_service_valid ? in_service_id + 5'd1 : 5'd0;
        end
        default:      rdata_nxt = '0;
      endcase
    end
  end

  // Claim clear is applied after the set so it wins for the claimed source.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q            <= '0;
      pending          <= '0;
      enable           <= '0;
      in_service_valid <= 1'b0;
      in_service_id    <= 5'd0;
      reg_rvalid       <= 1'b0;
      reg_rdata        <= '0;
    end else begin
      src_q      <= irq_src;
      pending    <= (pending | (set_src & ~block_mask)) & ~claim_mask;
      reg_rvalid <= reg_req;
      reg_rdata  <= rdata_nxt;
      if (wr && (reg_addr == ADDR_ENABLE)) enable <= reg_wdata[N_SRC-1:0];
      if (claim_fire) begin
        in_service_valid <= 1'b1;
        in_service_id    <= best;
      end else if (complete_fire) begin
        in_service_valid <= 1'b0;
        in_service_id    <= 5'd0;
      end
    end
  end

endmodule
